// File: rtl/tile_draw_sequencer.sv
// tile_draw_sequencer: pixel-write sequencer for the tile board.
// Boot draw of every tile, then flash / hold / restore per request.
module tile_draw_sequencer #(
  parameter int NUM_TILES    = 4,
  parameter int PIXELS       = 256,
  parameter int FLASH_CYCLES = 1000,
  localparam int TILE_W = $clog2(NUM_TILES),
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int HOLD_W = $clog2(FLASH_CYCLES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              flash_req,
  input  logic [TILE_W-1:0] flash_tile,
  output logic [TILE_W-1:0] tile_num,
  output logic [PIX_W-1:0]  pixel_idx,
  output logic              flash_colour,
  output logic              write_en,
  output logic              ready,
  output logic              done
);

  typedef enum logic [2:0] {
    BOOT_WAIT,
    BOOT_DRAW,
    IDLE,
    FLASH_DRAW,
    FLASH_HOLD,
    RESTORE_DRAW,
    DONE
  } state_t;

  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXELS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FLASH_CYCLES - 1);
  localparam logic [TILE_W:0]   TILE_CNT  = (TILE_W + 1)'(NUM_TILES);

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [TILE_W-1:0]   lat_q, lat_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                tile_ok;

  assign tile_ok = ({1'b0, flash_tile} < TILE_CNT);

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BOOT_WAIT;
      tile_q  <= '0;
      lat_q   <= '0;
      pix_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      lat_q   <= lat_d;
      pix_q   <= pix_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, counter stepping and Moore output decode.
  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    lat_d        = lat_q;
    pix_d        = pix_q;
    hold_d       = hold_q;
    tile_num     = '0;
    pixel_idx    = '0;
    flash_colour = 1'b0;
    write_en     = 1'b0;
    ready        = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      BOOT_WAIT: begin
        if (start) begin
          state_d = BOOT_DRAW;
          tile_d  = '0;
          pix_d   = '0;
        end
      end
      BOOT_DRAW: begin
        write_en  = 1'b1;
        tile_num  = tile_q;
        pixel_idx = pix_q;
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (tile_q == TILE_LAST) begin
            tile_d  = '0;
            state_d = DONE;
          end else begin
            tile_d = tile_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = BOOT_DRAW;
          tile_d  = '0;
          pix_d   = '0;
        end else if (flash_req && tile_ok) begin
          state_d = FLASH_DRAW;
          lat_d   = flash_tile;
          pix_d   = '0;
        end
      end
      FLASH_DRAW: begin
        write_en     = 1'b1;
        flash_colour = 1'b1;
        tile_num     = lat_q;
        pixel_idx    = pix_q;
        if (pix_q == PIX_LAST) begin
          pix_d   = '0;
          hold_d  = '0;
          state_d = FLASH_HOLD;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      FLASH_HOLD: begin
        tile_num = lat_q;
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          pix_d   = '0;
          state_d = RESTORE_DRAW;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RESTORE_DRAW: begin
        write_en  = 1'b1;
        tile_num  = lat_q;
        pixel_idx = pix_q;
        if (pix_q == PIX_LAST) begin
          pix_d   = '0;
          state_d = DONE;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = BOOT_WAIT;
    endcase
  end

endmodule

// File: tb/tb_tile_draw_sequencer.sv
// tb_tile_draw_sequencer: directed checks of boot, flash, priority,
// out-of-range requests and mid-draw reset.
module tb_tile_draw_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       flash_req = 1'b0;
  logic [1:0] flash_tile = '0;
  logic [1:0] tile_num;
  logic [1:0] pixel_idx;
  logic       flash_colour, write_en, ready, done;

  logic       start2 = 1'b0;
  logic       flash_req2 = 1'b0;
  logic [1:0] flash_tile2 = '0;
  logic [1:0] tile_num2;
  logic [1:0] pixel_idx2;
  logic       flash_colour2, write_en2, ready2, done2;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  tile_draw_sequencer #(
    .NUM_TILES(4), .PIXELS(4), .FLASH_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .flash_req(flash_req), .flash_tile(flash_tile),
    .tile_num(tile_num), .pixel_idx(pixel_idx),
    .flash_colour(flash_colour), .write_en(write_en),
    .ready(ready), .done(done)
  );

  tile_draw_sequencer #(
    .NUM_TILES(3), .PIXELS(4), .FLASH_CYCLES(3)
  ) dut3 (
    .clock(clock), .reset(reset), .start(start2),
    .flash_req(flash_req2), .flash_tile(flash_tile2),
    .tile_num(tile_num2), .pixel_idx(pixel_idx2),
    .flash_colour(flash_colour2), .write_en(write_en2),
    .ready(ready2), .done(done2)
  );

  // packed as {we, fc, ready, done, tile[1:0], pix[1:0]}
  function automatic logic [7:0] pk(
    input logic we, input logic fc, input logic rd,
    input logic dn, input int t, input int p);
    logic [1:0] tt, pp;
    tt = 2'(t);
    pp = 2'(p);
    return {we, fc, rd, dn, tt, pp};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {write_en, flash_colour, ready, done, tile_num, pixel_idx};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {write_en2, flash_colour2, ready2, done2, tile_num2, pixel_idx2};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic boot_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk(tag, pk(1, 0, 0, 0, i / 4, i % 4));
      tick();
    end
    chk({tag, "_done"}, pk(0, 0, 0, 1, 0, 0));
    tick();
    chk({tag, "_ready"}, pk(0, 0, 1, 0, 0, 0));
  endtask

  initial begin
    // reset
    tick();
    tick();
    chk("reset", pk(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick();
    chk("boot_wait", pk(0, 0, 0, 0, 0, 0));

    // boot draw
    start = 1'b1;
    tick();
    start = 1'b0;
    boot_check("boot");

    // flash tile 2 with flash_req held high throughout
    flash_req = 1'b1;
    flash_tile = 2'd2;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("flash_draw", pk(1, 1, 0, 0, 2, k));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("flash_hold", pk(0, 0, 0, 0, 2, 0));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk("restore", pk(1, 0, 0, 0, 2, k));
      tick();
    end
    chk("flash_done", pk(0, 0, 0, 1, 0, 0));
    tick();
    chk("flash_ready", pk(0, 0, 1, 0, 0, 0));
    flash_tile = 2'd1;
    tick();
    flash_req = 1'b0;
    chk("second_flash", pk(1, 1, 0, 0, 1, 0));
    for (int k = 0; k < 11; k++) tick();
    chk("second_done", pk(0, 0, 0, 1, 0, 0));
    tick();
    chk("second_ready", pk(0, 0, 1, 0, 0, 0));

    // start beats flash_req in the same cycle
    start = 1'b1;
    flash_req = 1'b1;
    flash_tile = 2'd1;
    tick();
    start = 1'b0;
    flash_req = 1'b0;
    boot_check("prio");

    // reset during restore pixel 2
    flash_req = 1'b1;
    flash_tile = 2'd3;
    tick();
    flash_req = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("pre_reset", pk(1, 0, 0, 0, 3, 2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset", pk(0, 0, 0, 0, 0, 0));
    flash_req = 1'b1;
    flash_tile = 2'd1;
    tick();
    flash_req = 1'b0;
    chk("wait_ignores_flash", pk(0, 0, 0, 0, 0, 0));
    tick();
    chk("no_done", pk(0, 0, 0, 0, 0, 0));
    start = 1'b1;
    tick();
    start = 1'b0;
    boot_check("reboot");

    // three-tile instance: out-of-range request ignored
    chk3("t3_wait", pk(0, 0, 0, 0, 0, 0));
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk3("t3_boot", pk(1, 0, 0, 0, i / 4, i % 4));
      tick();
    end
    chk3("t3_done", pk(0, 0, 0, 1, 0, 0));
    tick();
    chk3("t3_ready", pk(0, 0, 1, 0, 0, 0));
    flash_req2 = 1'b1;
    flash_tile2 = 2'd3;
    tick();
    chk3("t3_oor1", pk(0, 0, 1, 0, 0, 0));
    tick();
    flash_req2 = 1'b0;
    chk3("t3_oor2", pk(0, 0, 1, 0, 0, 0));
    flash_req2 = 1'b1;
    flash_tile2 = 2'd2;
    tick();
    flash_req2 = 1'b0;
    chk3("t3_valid", pk(1, 1, 0, 0, 2, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
